// File: rtl/hs_stream_source.sv
// hs_stream_source: valid/ready burst generator emitting base, base+incr, ... for len words.
// Define HS_SRC_THROTTLE_EN to gate word presentation with a 16-bit LFSR.
module hs_stream_source #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] incr,
    input  logic [LEN_W-1:0] len,
    input  logic             ready_down_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] sent_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_incr;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_cnt;
    logic             r_valid;
    logic             w_fire;
    logic             w_last;
    logic             w_gate;
`ifdef HS_SRC_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    // Taps 16,14,13,11; valid is registered from the next LFSR value so the
    // presenting cycle itself has lfsr[0]==1.
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_gate     = w_lfsr_nxt[0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= w_lfsr_nxt;
`else
    assign w_gate = 1'b1;
`endif
    assign w_fire = r_valid & ready_down_in;
    assign w_last = r_rem == LEN_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_incr  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt <= '0;
                    if (len != '0) begin
                        r_incr  <= incr;
                        r_data  <= base;
                        r_rem   <= len;
                        r_valid <= w_gate;
                        r_state <= S_SEND;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_SEND: if (w_fire) begin
                    r_cnt <= r_cnt + LEN_W'(1);
                    r_rem <= r_rem - LEN_W'(1);
                    if (w_last) begin
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_data  <= r_data + r_incr;
                        r_valid <= w_gate;
                    end
                end else if (!r_valid) begin
                    r_valid <= w_gate;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign data_out       = r_data;
    assign valid_down_out = r_valid;
    assign busy           = r_state != S_IDLE;
    assign done           = r_state == S_DONE;
    assign sent_cnt       = r_cnt;
endmodule

// File: tb/tb_hs_stream_source.sv
// tb_hs_stream_source: directed checks of hs_stream_source bursts, stalls, wrap and reset.
// Built with HS_SRC_THROTTLE_EN it runs a random-ready burst instead of the cycle-exact ones.
module tb_hs_stream_source;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [31:0] incr;
    logic [15:0] len;
    logic        ready;
    logic [31:0] data;
    logic        valid;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    int          n_chk = 0;
    int          n_err = 0;
    logic        p_v = 1'b0;
    logic        p_r = 1'b0;
    logic [31:0] p_d = '0;

    hs_stream_source #(.WIDTH(32), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .incr(incr), .len(len),
        .ready_down_in(ready), .data_out(data), .valid_down_out(valid),
        .busy(busy), .done(done), .sent_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] b, input logic [31:0] i, input logic [15:0] l);
        base  = b;
        incr  = i;
        len   = l;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Transmitter rule monitor: a stalled word must still be valid and unchanged next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_v <= 1'b0;
        end else begin
            if (p_v && !p_r) chk("hold", {31'd0, valid, data}, {31'd0, 1'b1, p_d});
            p_v <= valid;
            p_r <= ready;
            p_d <= data;
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        incr  = '0;
        len   = '0;
        ready = 1'b1;
        cyc();
        cyc();
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        cyc();
`ifndef HS_SRC_THROTTLE_EN
        cmd(32'h10, 32'd4, 16'd3);
        chk("basic_v1", valid, 1);
        chk("basic_d1", data, 32'h10);
        chk("basic_busy", busy, 1);
        cyc();
        chk("basic_d2", data, 32'h14);
        cyc();
        chk("basic_d3", data, 32'h18);
        cyc();
        chk("basic_done", done, 1);
        chk("basic_vdone", valid, 0);
        chk("basic_cnt", cnt, 3);
        cyc();
        chk("basic_idle_done", done, 0);
        chk("basic_idle_busy", busy, 0);
        chk("basic_cnt_hold", cnt, 3);

        cmd(32'h10, 32'd4, 16'd3);
        chk("bp_d1", data, 32'h10);
        cyc();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", valid, 1);
            chk("bp_data", data, 32'h14);
            cyc();
        end
        ready = 1'b1;
        chk("bp_data_rel", data, 32'h14);
        cyc();
        chk("bp_d3", data, 32'h18);
        chk("bp_nodone", done, 0);
        cyc();
        chk("bp_done_t9", done, 1);
        chk("bp_cnt", cnt, 3);
        cyc();

        cmd(32'h55, 32'd1, 16'd0);
        chk("zero_busy", busy, 1);
        chk("zero_done", done, 1);
        chk("zero_valid", valid, 0);
        chk("zero_cnt", cnt, 0);
        cyc();
        chk("zero_idle", busy, 0);
        chk("zero_valid2", valid, 0);
        chk("zero_done2", done, 0);

        cmd(32'hFFFF_FFFE, 32'd1, 16'd3);
        chk("wrap_d1", data, 32'hFFFF_FFFE);
        cyc();
        chk("wrap_d2", data, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_d3", data, 32'h0);
        chk("wrap_v3", valid, 1);
        cyc();
        chk("wrap_done", done, 1);
        cyc();

        cmd(32'h100, 32'd1, 16'd10);
        chk("busy_d1", data, 32'h100);
        cmd(32'h999, 32'd7, 16'd2);
        chk("busy_d2", data, 32'h101);
        chk("busy_cnt1", cnt, 1);
        cyc();
        chk("busy_d3", data, 32'h102);
        chk("busy_cnt2", cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", valid, 0);
        chk("mrst_data", data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_cnt", cnt, 0);
        cyc();
        chk("mrst_done2", done, 0);
        rst_n = 1'b1;
        cyc();
        cmd(32'h5, 32'd2, 16'd2);
        chk("after_d1", data, 32'h5);
        chk("after_v1", valid, 1);
        cyc();
        chk("after_d2", data, 32'h7);
        cyc();
        chk("after_done", done, 1);
        chk("after_cnt", cnt, 2);
        cyc();

        cmd(32'h0, 32'd1, 16'hFFFF);
        for (int i = 0; i < 70000 && !done; i++) cyc();
        chk("max_done", done, 1);
        chk("max_cnt", cnt, 16'hFFFF);
        chk("max_last", data, 32'hFFFE);
        cyc();
`else
        begin
            int k;
            k = 0;
            cmd(32'h7, 32'd3, 16'd100);
            for (int i = 0; i < 5000 && !done; i++) begin
                ready = 1'($urandom_range(0, 1));
                if (valid && ready) begin
                    chk("thr_data", data, 32'h7 + 32'd3 * 32'(k));
                    k++;
                end
                cyc();
            end
            ready = 1'b1;
            chk("thr_done", done, 1);
            chk("thr_cnt", cnt, 100);
            chk("thr_fires", k, 100);
            cyc();
            chk("thr_idle", busy, 0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
